// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal/vertical counters with registered,
// mutually coherent sync, visibility, coordinate and line/frame start outputs.
module vga_timing_gen #(
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned COORD_W    = 10
) (
  input  logic               pixelClk,
  input  logic               reset,
  input  logic               pixEn,
  output logic               hSync,
  output logic               vSync,
  output logic               hVis,
  output logic               vVis,
  output logic               de,
  output logic [COORD_W-1:0] xCor,
  output logic [COORD_W-1:0] yCor,
  output logic               lineStart,
  output logic               frameStart
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : gen_bad_total
    $error("vga_timing_gen: raster totals do not fit in COORD_W bits");
  end
  if (H_VIS == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_VIS == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || COORD_W == 0) begin : gen_bad_width
    $error("vga_timing_gen: width parameters must be non-zero");
  end

  localparam logic [COORD_W-1:0] HLast      = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] VLast      = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] HVisEnd    = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] VVisEnd    = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0] HSyncStart = COORD_W'(H_VIS + H_FP);
  localparam logic [COORD_W-1:0] HSyncEnd   = COORD_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VSyncStart = COORD_W'(V_VIS + V_FP);
  localparam logic [COORD_W-1:0] VSyncEnd   = COORD_W'(V_VIS + V_FP + V_SYNC);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic hvis_q, hvis_d, vvis_q, vvis_d, de_q, de_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  // Outputs are decoded from the next position so they always describe xCor/yCor.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hvis_d        = hvis_q;
    vvis_d        = vvis_q;
    de_d          = de_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pixEn) begin
      if (x_q == HLast) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
      hvis_d        = (x_d < HVisEnd);
      vvis_d        = (y_d < VVisEnd);
      de_d          = hvis_d & vvis_d;
      hsync_d       = (x_d >= HSyncStart && x_d < HSyncEnd) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d       = (y_d >= VSyncStart && y_d < VSyncEnd) ? V_SYNC_POL : ~V_SYNC_POL;
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  // Reset parks the raster on the last position so the first enabled edge lands on (0,0).
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      x_q           <= HLast;
      y_q           <= VLast;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      hvis_q        <= 1'b0;
      vvis_q        <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hvis_q        <= hvis_d;
      vvis_q        <= vvis_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign xCor       = x_q;
  assign yCor       = y_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign hVis       = hvis_q;
  assign vVis       = vvis_q;
  assign de         = de_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 pixel-counter block.
- Runs from the pixel clock and drives sync, visibility and coordinate signals to the pixel pipeline and the VGA pins.
- Uses separate horizontal and vertical counters, with porch and sync widths and sync polarity set by parameters.
- Adds a pixel-enable input for clock division, line and frame start strobes, and registered, mutually coherent outputs.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- H_SYNC_POL, 0, hSync active level (0 = active-low)
- V_SYNC_POL, 0, vSync active level (0 = active-low)
- COORD_W, 10, width of the coordinate outputs

Ports:
- pixelClk  in  1  pixel clock
- reset  in  1  asynchronous reset, active-high
- pixEn  in  1  advance enable; the raster moves one pixel on each pixelClk edge where pixEn=1
- hSync  out  1  horizontal sync, at the active level set by H_SYNC_POL
- vSync  out  1  vertical sync, at the active level set by V_SYNC_POL
- hVis  out  1  current x is in the visible region
- vVis  out  1  current y is in the visible region
- de  out  1  display enable, equal to hVis & vVis
- xCor  out  COORD_W  current horizontal position
- yCor  out  COORD_W  current vertical position
- lineStart  out  1  one-clock strobe on entering x=0
- frameStart  out  1  one-clock strobe on entering (0,0)

Behaviour:
- Derived values:
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP (default 800)
  - V_TOT = V_VIS+V_FP+V_SYNC+V_BP (default 525)
- Elaboration error if H_TOT > 2**COORD_W, V_TOT > 2**COORD_W, or any width parameter is 0.
- Reset asserted (asynchronous):
  - Internal counters are set to x=H_TOT-1, y=V_TOT-1.
  - Outputs: xCor=H_TOT-1, yCor=V_TOT-1, hVis=vVis=de=0, lineStart=frameStart=0.
  - hSync and vSync are driven to their inactive levels (~H_SYNC_POL, ~V_SYNC_POL).
- First enabled edge after reset release wraps the raster to (0,0) with lineStart=frameStart=1.
- Counter update on a pixelClk edge with pixEn=1:
  - x = (x==H_TOT-1) ? 0 : x+1.
  - When x wraps, y = (y==V_TOT-1) ? 0 : y+1; otherwise y holds.
- pixEn=0: x, y and all level outputs hold their values.
- All outputs are registered and are updated in the same edge as the new (x,y), so every output describes the position shown on xCor/yCor. There is no combinational path from any input to any output.
- Horizontal regions, applied to the new x:
  - Visible: 0..H_VIS-1. hVis=1.
  - Front porch: H_VIS..H_VIS+H_FP-1. hVis=0, hSync inactive.
  - Sync: H_VIS+H_FP..H_VIS+H_FP+H_SYNC-1. hSync active.
  - Back porch: the remaining positions up to H_TOT-1. hSync inactive.
- Vertical regions, applied to the new y, follow the same rule with the V_* parameters. vSync depends on y only, so it changes only at x=0.
- Region boundaries are inclusive/exclusive exactly as stated above; every index from 0 to H_TOT-1 (or V_TOT-1) falls in exactly one region.
- Strobes:
  - lineStart=1 for exactly one pixelClk cycle after an enabled edge that produces x=0.
  - frameStart=1 for exactly one pixelClk cycle after an enabled edge that produces (0,0).
  - Both strobes are cleared on the next pixelClk edge whatever the value of pixEn.
- Reset asserted mid-frame: all state returns immediately and asynchronously to the reset values. Nothing partial survives, and the next frame starts cleanly at (0,0).
- reset and pixEn asserted together: reset wins.

Test Plan:
- Reset, then pixEn=1 constantly -> during reset xCor=799, yCor=524, hSync=vSync=1, de=0. First edge after release -> (0,0), hVis=vVis=de=1, lineStart=frameStart=1. Next edge -> (1,0), both strobes 0.
- Horizontal sweep on line 0 -> hVis=1 at x=639 and 0 at x=640. hSync=1 at x=655, 0 for x=656..751, 1 again at x=752. de mirrors hVis.
- Line and frame wrap -> (799,3) goes to (0,4) with lineStart=1 and frameStart=0. vSync=0 only for y=490..491 across all x. (799,524) goes to (0,0) with frameStart=1. Exactly 420000 enabled edges pass between consecutive frameStart pulses.
- pixEn toggling 1,0,1,0 -> position advances only on the enabled edges. Level outputs hold across the disabled cycles. lineStart lasts exactly one clock even when the following cycle has pixEn=0.
- Reset asserted at (300,200) with hVis=1 -> outputs go to their reset values asynchronously, before the next clock edge. After release the first enabled edge gives (0,0) with frameStart=1.
- Small build, H=4/1/2/1 (H_TOT 8), V=3/1/1/1 (V_TOT 6), H_SYNC_POL=V_SYNC_POL=1 -> hSync=1 only at x=5..6; vSync=1 only at y=4; frame period is 48 enabled edges.
